regbank_write_arb: RTL

REGBANK_WRITE_ARB -- requirements
Module: regbank_write_arb

---
 rtl/regbank_pkg.sv | 8 +
 rtl/regbank_write_arb_if.sv | 32 +++
 rtl/regbank_write_arb_rr_pick4.sv | 20 ++
 rtl/regbank_write_arb.sv | 90 +++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and FSM state type for the register-bank write arbiter
// Contents: NREQ (requesters), AW (address width), DW (data width), state_t {ARB, LOCKED}
package regbank_pkg;
   localparam int NREQ = 4;
   localparam int AW = 2;
   localparam int DW = 32;
   typedef enum logic {ARB, LOCKED} state_t;
endpackage

// File: rtl/regbank_write_arb_if.sv
// regbank_write_arb_if: requester, register-bank write and read-path signals of the write arbiter
// master: requesters/bank drive req_valid, req_lock, req_wa, req_wdata, ra1, ra2, bank_rdata1/2
//         and observe req_ready, write, wa, wdata, rdata1/2
// slave:  the arbiter, directions reversed
interface regbank_write_arb_if #(
   parameter int NREQ = regbank_pkg::NREQ,
   parameter int AW = regbank_pkg::AW,
   parameter int DW = regbank_pkg::DW
);
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_lock;
   logic [NREQ*AW-1:0] req_wa;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0] req_ready;
   logic write;
   logic [AW-1:0] wa;
   logic [DW-1:0] wdata;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra2;
   logic [DW-1:0] bank_rdata1;
   logic [DW-1:0] bank_rdata2;
   logic [DW-1:0] rdata1;
   logic [DW-1:0] rdata2;
   modport master (
      output req_valid, req_lock, req_wa, req_wdata, ra1, ra2, bank_rdata1, bank_rdata2,
      input req_ready, write, wa, wdata, rdata1, rdata2
   );
   modport slave (
      input req_valid, req_lock, req_wa, req_wdata, ra1, ra2, bank_rdata1, bank_rdata2,
      output req_ready, write, wa, wdata, rdata1, rdata2
   );
endinterface

// File: rtl/regbank_write_arb_rr_pick4.sv
// rr_pick4: 4-way round-robin pick, searching from i_ptr+1 upward (mod 4)
// Ports: i_valid[3:0] requests, i_ptr[1:0] last winner, o_grant[3:0] one-hot, o_idx[1:0] winner index
module rr_pick4 (
   input  logic [3:0] i_valid,
   input  logic [1:0] i_ptr,
   output logic [3:0] o_grant,
   output logic [1:0] o_idx
);
   // Scan from farthest to nearest so the nearest valid requester is assigned last and wins.
   always_comb begin
      o_grant = '0;
      o_idx = '0;
      for (int k = 4; k >= 1; k--) begin
         if (i_valid[2'(i_ptr + 2'(k))]) begin
            o_idx = 2'(i_ptr + 2'(k));
            o_grant = 4'b0001 << o_idx;
         end
      end
   end
endmodule

// File: rtl/regbank_write_arb.sv
// regbank_write_arb: round-robin write arbiter with lock, feeding a registered write port of a register bank
// Ports: clk, rst (sync, active-high); bus (regbank_write_arb_if.slave) carrying requests, the
//        registered write (write/wa/wdata) and the read path (ra1/ra2 -> rdata1/rdata2)
// Option: define REGBANK_WRITE_ARB_BYPASS_EN to forward the pending write onto matching read ports
module regbank_write_arb
   import regbank_pkg::*;
#(
   parameter int NREQ = regbank_pkg::NREQ,
   parameter int AW = regbank_pkg::AW,
   parameter int DW = regbank_pkg::DW
) (
   input logic clk,
   input logic rst,
   regbank_write_arb_if.slave bus
);
   state_t r_state;
   state_t w_state_nxt;
   logic [1:0] r_ptr;
   logic [1:0] r_owner;
   logic [1:0] w_ptr_nxt;
   logic [1:0] w_owner_nxt;
   logic [1:0] w_win;
   logic [1:0] w_rr_idx;
   logic [3:0] w_rr_grant;
   logic [NREQ-1:0] w_ready;
   logic w_xfer;
   logic r_write;
   logic [AW-1:0] r_wa;
   logic [DW-1:0] r_wdata;

   rr_pick4 u_pick (
      .i_valid(bus.req_valid),
      .i_ptr(r_ptr),
      .o_grant(w_rr_grant),
      .o_idx(w_rr_idx)
   );

   // In LOCKED, xfer implies req_valid[owner], so both exit conditions reduce to !req_lock[owner].
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt = r_ptr;
      w_owner_nxt = r_owner;
      w_win = r_state == LOCKED ? r_owner : w_rr_idx;
      w_ready = rst ? '0 : r_state == LOCKED ? (bus.req_valid[r_owner] ? NREQ'(1) << r_owner : '0) : w_rr_grant;
      w_xfer = |w_ready;
      if (r_state == ARB) begin
         if (w_xfer && bus.req_lock[w_win]) begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_win;
         end else if (w_xfer) begin
            w_ptr_nxt = w_win;
         end
      end else if (!bus.req_lock[r_owner]) begin
         w_state_nxt = ARB;
         w_ptr_nxt = r_owner;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB;
         r_ptr <= 2'd3;
         r_owner <= '0;
         r_write <= 1'b0;
         r_wa <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_write <= w_xfer;
         if (w_xfer) begin
            r_wa <= bus.req_wa[w_win*AW +: AW];
            r_wdata <= bus.req_wdata[w_win*DW +: DW];
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.write = r_write;
   assign bus.wa = r_wa;
   assign bus.wdata = r_wdata;
`ifdef REGBANK_WRITE_ARB_BYPASS_EN
   assign bus.rdata1 = (r_write && r_wa == bus.ra1) ? r_wdata : bus.bank_rdata1;
   assign bus.rdata2 = (r_write && r_wa == bus.ra2) ? r_wdata : bus.bank_rdata2;
`else
   assign bus.rdata1 = bus.bank_rdata1;
   assign bus.rdata2 = bus.bank_rdata2;
`endif
endmodule
